// File: rtl/booth_pp_gen_seq_pkg.sv
// Shared widths, Booth digit encodings and FSM state codes for the
// sequential radix-4 Booth partial-product generator.
package booth_pp_gen_seq_pkg;

  localparam int NUM_PP = 16;
  localparam int PP_W   = 64;
  localparam int OP_W   = 32;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_P1   = 3'd1,
    BOOTH_P2   = 3'd2,
    BOOTH_M1   = 3'd3,
    BOOTH_M2   = 3'd4
  } booth_digit_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_VALID = 2'd2
  } state_e;

  // Window is {Q[2i+1], Q[2i], Q[2i-1]}.
  function automatic booth_digit_e booth_decode(input logic [2:0] win);
    booth_digit_e d;
    case (win)
      3'b001, 3'b010: d = BOOTH_P1;
      3'b011:         d = BOOTH_P2;
      3'b100:         d = BOOTH_M2;
      3'b101, 3'b110: d = BOOTH_M1;
      default:        d = BOOTH_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen_seq_sel.sv
// Combinational selector for one Booth partial product: picks 0/+-M/+-2M
// from a 3-bit window and shifts it into place for digit digit_idx_i.
module booth_pp_sel
  import booth_pp_gen_seq_pkg::*;
(
  input  logic [2:0]      window_i,
  input  logic [PP_W-1:0] m_sx_i,
  input  logic [3:0]      digit_idx_i,
  output logic [PP_W-1:0] pp_o
);

  logic [PP_W-1:0] m2;
  logic [PP_W-1:0] mult;

  assign m2 = m_sx_i << 1;

  always_comb begin
    mult = '0;
    case (booth_decode(window_i))
      BOOTH_P1: mult = m_sx_i;
      BOOTH_P2: mult = m2;
      BOOTH_M1: mult = ~m_sx_i + PP_W'(1);
      BOOTH_M2: mult = ~m2 + PP_W'(1);
      default:  mult = '0;
    endcase
    pp_o = mult << {digit_idx_i, 1'b0};
  end

endmodule

// File: rtl/booth_pp_gen_seq.sv
// Sequential radix-4 Booth partial-product generator: latches M/Q, builds
// PP_PER_CYCLE partial products per cycle into a 16x64 output bank.
module booth_pp_gen_seq
  import booth_pp_gen_seq_pkg::*;
#(
  parameter int PP_PER_CYCLE = 4
)
(
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        mcand,
  input  logic [OP_W-1:0]        mplier,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_PP*PP_W-1:0] pp_bus
);

  localparam int N_GEN = NUM_PP / PP_PER_CYCLE;
  localparam int CNT_W = (N_GEN > 1) ? $clog2(N_GEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_GEN - 1);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [OP_W-1:0]             m_q, m_d;
  logic [OP_W-1:0]             q_q, q_d;
  logic [NUM_PP-1:0][PP_W-1:0] pp_q, pp_d;

  logic [PP_W-1:0] m_sx;
  logic [OP_W:0]   q_ext;
  logic [3:0]      digit_idx [PP_PER_CYCLE];
  logic [PP_W-1:0] pp_sel    [PP_PER_CYCLE];

  assign m_sx  = {{(PP_W-OP_W){m_q[OP_W-1]}}, m_q};
  // Appended zero supplies Q[-1] for digit 0.
  assign q_ext = {q_q, 1'b0};

  for (genvar k = 0; k < PP_PER_CYCLE; k++) begin : g_sel
    assign digit_idx[k] = 4'(int'(cnt_q) * PP_PER_CYCLE + k);

    booth_pp_sel u_sel (
      .window_i    (q_ext[{digit_idx[k], 1'b0} +: 3]),
      .m_sx_i      (m_sx),
      .digit_idx_i (digit_idx[k]),
      .pp_o        (pp_sel[k])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    q_d     = q_q;
    pp_d    = pp_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          m_d     = mcand;
          q_d     = mplier;
          cnt_d   = '0;
          pp_d    = '0;
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        for (int k = 0; k < PP_PER_CYCLE; k++) begin
          pp_d[digit_idx[k]] = pp_sel[k];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      pp_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      q_q     <= q_d;
      pp_q    <= pp_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_VALID);
  assign pp_bus    = pp_q;

endmodule

// File: tb/tb_booth_pp_gen_seq.sv
// Self-checking bench for booth_pp_gen_seq: vector table, handshake corner
// sequences and random pairs, checked through an expected-result queue.
module tb_booth_pp_gen_seq;

  localparam int PPC   = 4;
  localparam int N_GEN = 16 / PPC;

  logic          clk = 1'b0;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   mcand;
  logic [31:0]   mplier;
  logic          out_valid;
  logic          out_ready;
  logic [1023:0] pp_bus;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] m;
    logic [31:0] q;
    logic [63:0] exp_sum;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[9];
  vec_t mon_e;
  logic [1023:0] mon_exp;
  logic [1023:0] snap;

  booth_pp_gen_seq #(.PP_PER_CYCLE(PPC)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .mplier    (mplier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_bus    (pp_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_pp(input logic [31:0] m, input logic [31:0] q, input int i);
    logic [32:0] qe;
    logic [2:0]  b;
    longint      d;
    longint      v;
    qe = {q, 1'b0};
    b  = qe[2*i +: 3];
    case (b)
      3'b001, 3'b010: d = 1;
      3'b011:         d = 2;
      3'b100:         d = -2;
      3'b101, 3'b110: d = -1;
      default:        d = 0;
    endcase
    v = d * longint'($signed(m));
    return 64'(v) << (2*i);
  endfunction

  function automatic logic [63:0] term_sum(input logic [1023:0] bus);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + bus[64*i +: 64];
    return s;
  endfunction

  function automatic logic [63:0] sprod(input logic [31:0] m, input logic [31:0] q);
    return 64'(longint'($signed(m)) * longint'($signed(q)));
  endfunction

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int first;
    checks++;
    if (act !== exp) begin
      errors++;
      first = 0;
      for (int i = 15; i >= 0; i--) if (act[64*i +: 64] !== exp[64*i +: 64]) first = i;
      $display("FAIL %s: pp%0d got %h expected %h", name, first,
               act[64*first +: 64], exp[64*first +: 64]);
    end
  endtask

  // Output side: a set is consumed at the posedge following a negedge where
  // out_valid && out_ready; compare it against the oldest accepted pair.
  always @(negedge clk) begin
    if (!clr && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got out_valid=1 expected no pending operation");
      end else begin
        mon_e = sb_q.pop_front();
        for (int i = 0; i < 16; i++) mon_exp[64*i +: 64] = model_pp(mon_e.m, mon_e.q, i);
        chk_bus("pp_bank", pp_bus, mon_exp);
        chk64("term_sum", term_sum(pp_bus), mon_e.exp_sum);
      end
    end
  end

  // Call at posedge+2; returns at posedge+2 right after the accept edge.
  task automatic send(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp);
    int n;
    n        = 0;
    in_valid = 1'b1;
    mcand    = m;
    mplier   = q;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      sb_q.push_back('{m: m, q: q, exp_sum: exp});
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    mcand    = $urandom;
    mplier   = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk64("drain", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk64("wait_valid", 64'(out_valid), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] rm, rq;

    tbl[0] = '{m: 32'd3,          q: 32'd5,          exp_sum: 64'd15};
    tbl[1] = '{m: 32'hFFFF_FFF9,  q: 32'd6,          exp_sum: 64'hFFFF_FFFF_FFFF_FFD6};
    tbl[2] = '{m: 32'h8000_0000,  q: 32'h8000_0000,  exp_sum: 64'h4000_0000_0000_0000};
    tbl[3] = '{m: 32'hFFFF_FFFF,  q: 32'hFFFF_FFFF,  exp_sum: 64'd1};
    tbl[4] = '{m: 32'h1234_5678,  q: 32'd0,          exp_sum: 64'd0};
    tbl[5] = '{m: 32'hFFFF_FFFB,  q: 32'hFFFF_FFFF,  exp_sum: 64'd5};
    tbl[6] = '{m: 32'h7FFF_FFFF,  q: 32'h8000_0000,  exp_sum: 64'hC000_0000_8000_0000};
    tbl[7] = '{m: 32'h8000_0000,  q: 32'd2,          exp_sum: 64'hFFFF_FFFF_0000_0000};
    tbl[8] = '{m: 32'h8000_0000,  q: 32'hFFFF_FFFE,  exp_sum: 64'h0000_0001_0000_0000};

    clr       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mcand     = '0;
    mplier    = '0;
    repeat (2) @(posedge clk);
    #2;
    clr = 1'b0;
    @(negedge clk);
    chk64("rst_in_ready", 64'(in_ready), 64'd1);
    chk64("rst_out_valid", 64'(out_valid), 64'd0);
    chk_bus("rst_pp_bus", pp_bus, '0);
    @(posedge clk);
    #2;

    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(tbl[i].m, tbl[i].q, tbl[i].exp_sum);
    drain();

    // Latency: out_valid low as seen by edges T+1..T+N_GEN, high at T+N_GEN+1.
    out_ready = 1'b0;
    send(32'd3, 32'd5, 64'd15);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 40) begin
      k++;
      @(negedge clk);
    end
    chk64("latency_edges", 64'(k + 1), 64'(N_GEN + 1));

    // Backpressure with competing operands on the input.
    snap = pp_bus;
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    mcand    = 32'd9;
    mplier   = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk64("bp_out_valid", 64'(out_valid), 64'd1);
      chk64("bp_in_ready", 64'(in_ready), 64'd0);
      chk_bus("bp_pp_bus", pp_bus, snap);
    end
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    @(negedge clk);
    chk64("post_valid_out_valid", 64'(out_valid), 64'd0);
    chk_bus("post_valid_hold", pp_bus, snap);
    repeat (N_GEN + 3) @(negedge clk);
    chk64("no_accept_during_bp", 64'(out_valid), 64'd0);
    chk64("bp_sb_empty", 64'(sb_q.size()), 64'd0);

    // Accept clears the bank before the first GEN write.
    @(posedge clk);
    #2;
    send(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    @(negedge clk);
    chk_bus("accept_clears_bank", pp_bus, '0);
    out_ready = 1'b1;
    drain();

    // clr in the middle of GEN.
    out_ready = 1'b1;
    send(32'd12345, 32'd678, sprod(32'd12345, 32'd678));
    sb_q.delete();
    clr = 1'b1;
    @(posedge clk);
    #2;
    clr = 1'b0;
    @(negedge clk);
    chk64("clr_gen_in_ready", 64'(in_ready), 64'd1);
    chk64("clr_gen_out_valid", 64'(out_valid), 64'd0);
    chk_bus("clr_gen_pp_bus", pp_bus, '0);
    repeat (N_GEN + 3) @(negedge clk);
    chk64("clr_gen_stays_idle", 64'(out_valid), 64'd0);

    // clr while VALID.
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    send(32'd77, 32'd99, sprod(32'd77, 32'd99));
    wait_valid();
    sb_q.delete();
    @(posedge clk);
    #2;
    clr = 1'b1;
    @(posedge clk);
    #2;
    clr = 1'b0;
    @(negedge clk);
    chk64("clr_valid_out_valid", 64'(out_valid), 64'd0);
    chk_bus("clr_valid_pp_bus", pp_bus, '0);
    @(posedge clk);
    #2;

    // Random pairs with random downstream stall lengths.
    for (int i = 0; i < 1500; i++) begin
      rm = $urandom;
      rq = $urandom;
      if (i % 50 == 0) rm = 32'h8000_0000;
      if (i % 70 == 0) rq = 32'hFFFF_FFFF;
      out_ready = 1'b1;
      send(rm, rq, sprod(rm, rq));
      out_ready = 1'b0;
      repeat ($urandom_range(0, N_GEN + 3)) begin
        @(posedge clk);
        #2;
      end
      out_ready = 1'b1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
